// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
//
// Multiplies by shift-add and divides by restoring shift-subtract. Both work on
// operand magnitudes, and the sign is fixed up after the last iteration.
// BITS_PER_CYCLE iterations of the 1-bit step are chained per clock. Divides by
// zero and the signed-overflow divide skip the iteration phase and finish one
// edge after acceptance.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   flush              synchronous abort of the in-flight operation
//   in_valid/in_ready  operand handshake; in_ready is high only in IDLE
//   op, a, b           funct3 opcode, rs1 and rs2 operands
//   out_valid/out_ready result handshake; result is held until out_ready
//   result             operation result
//   busy               high while computing or holding a result
//   dbg_state_o        current FSM state (0 IDLE, 1 CALC, 2 DONE)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid and its data stable until that edge.
module muldiv_unit #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy,
    output logic [1:0]      dbg_state_o
);

    localparam int ITER = XLEN / BITS_PER_CYCLE;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [XLEN-1:0]   ONE_X  = XLEN'(1);
    localparam logic [2*XLEN-1:0] ONE_2X = (2*XLEN)'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic              neg_a_q, neg_a_d, neg_b_q, neg_b_d;
    logic [XLEN-1:0]   mag_q, mag_d;       // multiplicand (mul) or divisor (div)
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [2*XLEN:0]   acc_q, acc_d;       // {partial product, multiplier} or quotient in low half
    logic [CW-1:0]     cnt_q, cnt_d;

    logic              accept, last_iter;

    // Operand decode at acceptance
    logic              is_div_in, sgn_a_in, sgn_b_in, neg_a_in, neg_b_in;
    logic              b_zero, ovf_in, special_in;
    logic [XLEN-1:0]   mag_a_in, mag_b_in, spec_res;

    // Iteration and final result
    logic [2*XLEN:0]   acc_n;
    logic [XLEN-1:0]   rem_n;
    logic [XLEN:0]     rem_sh, mul_sum;
    logic              q_bit;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, res_calc;

    assign accept    = in_valid && (state_q == S_IDLE) && !flush;
    assign last_iter = (cnt_q == CW'(ITER - 1));

    always_comb begin
        is_div_in  = op[2];
        // Signed operands: MUL/MULH/MULHSU/DIV/REM for a; MUL/MULH/DIV/REM for b.
        sgn_a_in   = is_div_in ? ~op[0] : (op[1:0] != 2'b11);
        sgn_b_in   = is_div_in ? ~op[0] : ~op[1];
        neg_a_in   = sgn_a_in & a[XLEN-1];
        neg_b_in   = sgn_b_in & b[XLEN-1];
        mag_a_in   = neg_a_in ? (~a + ONE_X) : a;
        mag_b_in   = neg_b_in ? (~b + ONE_X) : b;
        b_zero     = ~|b;
        ovf_in     = ~op[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (&b);
        special_in = is_div_in && (b_zero || ovf_in);
        // op[1] distinguishes REM/REMU from DIV/DIVU.
        if (b_zero) spec_res = op[1] ? a : '1;
        else        spec_res = op[1] ? '0 : a;
    end

    // BITS_PER_CYCLE chained single-bit steps.
    always_comb begin
        acc_n   = acc_q;
        rem_n   = rem_q;
        rem_sh  = '0;
        mul_sum = '0;
        q_bit   = 1'b0;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            if (op_q[2]) begin
                rem_sh = {rem_n, acc_n[XLEN-1]};
                q_bit  = (rem_sh >= {1'b0, mag_q});
                if (q_bit) rem_n = XLEN'(rem_sh - {1'b0, mag_q});
                else       rem_n = rem_sh[XLEN-1:0];
                acc_n = {acc_n[2*XLEN:XLEN], acc_n[XLEN-2:0], q_bit};
            end else begin
                // The top accumulator bit is always zero before the add, so the
                // XLEN+1-bit sum cannot overflow.
                mul_sum = acc_n[2*XLEN:XLEN] + (acc_n[0] ? {1'b0, mag_q} : '0);
                acc_n   = {1'b0, mul_sum, acc_n[XLEN-1:1]};
            end
        end
    end

    always_comb begin
        prod_s = (neg_a_q ^ neg_b_q) ? (~acc_n[2*XLEN-1:0] + ONE_2X) : acc_n[2*XLEN-1:0];
        quo_s  = (neg_a_q ^ neg_b_q) ? (~acc_n[XLEN-1:0] + ONE_X) : acc_n[XLEN-1:0];
        rem_s  = neg_a_q ? (~rem_n + ONE_X) : rem_n;
        case (op_q)
            3'b000:                 res_calc = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: res_calc = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         res_calc = quo_s;
            default:                res_calc = rem_s;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = special_in ? S_DONE : S_CALC;
            S_CALC:  if (last_iter) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    // FSM: outputs
    always_comb begin
        in_ready    = (state_q == S_IDLE);
        out_valid   = (state_q == S_DONE);
        busy        = (state_q == S_CALC) || (state_q == S_DONE);
        dbg_state_o = state_q;
    end

    assign result = result_q;

    // Datapath next state
    always_comb begin
        op_d     = op_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        mag_d    = mag_q;
        rem_d    = rem_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        if (state_q == S_IDLE && accept) begin
            op_d    = op;
            neg_a_d = neg_a_in;
            neg_b_d = neg_b_in;
            cnt_d   = '0;
            rem_d   = '0;
            if (is_div_in) begin
                mag_d = mag_b_in;
                acc_d = {(XLEN+1)'(0), mag_a_in};
            end else begin
                mag_d = mag_a_in;
                acc_d = {(XLEN+1)'(0), mag_b_in};
            end
            if (special_in) result_d = spec_res;
        end else if (state_q == S_CALC) begin
            acc_d = acc_n;
            rem_d = rem_n;
            cnt_d = cnt_q + CW'(1);
            if (last_iter) result_d = res_calc;
        end
        if (flush) result_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            mag_q    <= '0;
            rem_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            op_q     <= op_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            mag_q    <= mag_d;
            rem_q    <= rem_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic flush;
    always #5 clk = ~clk;

    // index 0: BITS_PER_CYCLE=1, index 1: BITS_PER_CYCLE=4
    logic        iv   [2];
    logic [2:0]  opx  [2];
    logic [31:0] ax   [2];
    logic [31:0] bx   [2];
    logic        ordy [2];
    logic        irdy [2];
    logic        ov   [2];
    logic [31:0] res  [2];
    logic        bsy  [2];
    logic [1:0]  dbg  [2];

    muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) u_bpc1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(iv[0]), .in_ready(irdy[0]), .op(opx[0]), .a(ax[0]), .b(bx[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .result(res[0]), .busy(bsy[0]),
        .dbg_state_o(dbg[0])
    );

    muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) u_bpc4 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(iv[1]), .in_ready(irdy[1]), .op(opx[1]), .a(ax[1]), .b(bx[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .result(res[1]), .busy(bsy[1]),
        .dbg_state_o(dbg[1])
    );

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int checks = 0;
    int fails  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: RV32M semantics via 64-bit arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] xs, ys, xu, yu;
        logic [63:0] p;
        logic [31:0] r;
        logic ovf;
        xs  = {{32{x[31]}}, x};
        ys  = {{32{y[31]}}, y};
        xu  = {32'b0, x};
        yu  = {32'b0, y};
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        p   = '0;
        r   = '0;
        case (o)
            3'd0: begin p = xs * ys; r = p[31:0];  end
            3'd1: begin p = xs * ys; r = p[63:32]; end
            3'd2: begin p = xs * yu; r = p[63:32]; end
            3'd3: begin p = xu * yu; r = p[63:32]; end
            3'd4: begin
                if (y == 0) r = 32'hFFFF_FFFF;
                else if (ovf) r = x;
                else begin p = xs / ys; r = p[31:0]; end
            end
            3'd5: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) r = x;
                else if (ovf) r = 32'h0;
                else begin p = xs % ys; r = p[31:0]; end
            end
            default: r = (y == 0) ? x : x % y;
        endcase
        return r;
    endfunction

    function automatic bit is_special(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        return o[2] && ((y == 0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
    endfunction

    // ---------------- driver tasks ----------------
    task automatic run_op(input int s, input logic [2:0] o, input logic [31:0] aa,
                          input logic [31:0] bb, input logic [31:0] e, input int hold);
        int n;
        int lat;
        logic [31:0] exp_v;
        lat = is_special(o, aa, bb) ? 1 : ((s == 0) ? 33 : 9);
        exp_q.push_back(e);
        @(negedge clk);
        check($sformatf("dut%0d in_ready_idle op%0d", s, o), irdy[s], 1);
        iv[s] = 1'b1; opx[s] = o; ax[s] = aa; bx[s] = bb;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        while (ov[s] !== 1'b1 && n < 100) begin
            // Junk on the input side while busy must be ignored.
            iv[s] = 1'($urandom_range(0, 1));
            opx[s] = 3'($urandom_range(0, 7));
            ax[s] = $urandom(); bx[s] = $urandom();
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        iv[s] = 1'b0;
        exp_v = exp_q.pop_front();
        check($sformatf("dut%0d latency op%0d", s, o), n, lat);
        check($sformatf("dut%0d result op%0d a=%h b=%h", s, o, aa, bb), res[s], exp_v);
        check($sformatf("dut%0d busy_done op%0d", s, o), bsy[s], 1);
        check($sformatf("dut%0d in_ready_done op%0d", s, o), irdy[s], 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("dut%0d hold_valid c%0d", s, i), ov[s], 1);
            check($sformatf("dut%0d hold_result c%0d", s, i), res[s], exp_v);
            check($sformatf("dut%0d hold_in_ready c%0d", s, i), irdy[s], 0);
        end
        ordy[s] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ordy[s] = 1'b0;
        check($sformatf("dut%0d out_valid_after_hs", s), ov[s], 0);
        check($sformatf("dut%0d in_ready_after_hs", s), irdy[s], 1);
        check($sformatf("dut%0d busy_after_hs", s), bsy[s], 0);
    endtask

    task automatic watch_no_valid(input int s, input int cycles, input string tag);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (ov[s] !== 1'b0) seen++;
        end
        check($sformatf("dut%0d %s", s, tag), seen, 0);
    endtask

    // Accept a normal op, let it run k edges into CALC, then flush.
    task automatic flush_mid(input int s, input int k);
        @(negedge clk);
        iv[s] = 1'b1; opx[s] = 3'd3; ax[s] = $urandom(); bx[s] = $urandom();
        @(posedge clk);
        @(negedge clk);
        iv[s] = 1'b0;
        check($sformatf("dut%0d busy_before_flush", s), bsy[s], 1);
        repeat (k) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        check($sformatf("dut%0d flush_in_ready", s), irdy[s], 1);
        check($sformatf("dut%0d flush_busy", s), bsy[s], 0);
        check($sformatf("dut%0d flush_out_valid", s), ov[s], 0);
        watch_no_valid(s, 40, "flush_no_valid");
    endtask

    // ---------------- directed table ----------------
    logic [2:0]  d_op [12];
    logic [31:0] d_a  [12];
    logic [31:0] d_b  [12];
    logic [31:0] d_e  [12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        d_op[0]  = 3'd0; d_a[0]  = 32'd7;          d_b[0]  = 32'hFFFF_FFFD; d_e[0]  = 32'hFFFF_FFEB;
        d_op[1]  = 3'd1; d_a[1]  = 32'h8000_0000; d_b[1]  = 32'h8000_0000; d_e[1]  = 32'h4000_0000;
        d_op[2]  = 3'd2; d_a[2]  = 32'hFFFF_FFFF; d_b[2]  = 32'hFFFF_FFFF; d_e[2]  = 32'hFFFF_FFFF;
        d_op[3]  = 3'd3; d_a[3]  = 32'hFFFF_FFFF; d_b[3]  = 32'hFFFF_FFFF; d_e[3]  = 32'hFFFF_FFFE;
        d_op[4]  = 3'd4; d_a[4]  = 32'hFFFF_FFF9; d_b[4]  = 32'd2;         d_e[4]  = 32'hFFFF_FFFD;
        d_op[5]  = 3'd6; d_a[5]  = 32'hFFFF_FFF9; d_b[5]  = 32'd2;         d_e[5]  = 32'hFFFF_FFFF;
        d_op[6]  = 3'd5; d_a[6]  = 32'd100;        d_b[6]  = 32'd7;         d_e[6]  = 32'd14;
        d_op[7]  = 3'd7; d_a[7]  = 32'd100;        d_b[7]  = 32'd7;         d_e[7]  = 32'd2;
        d_op[8]  = 3'd5; d_a[8]  = 32'd5;          d_b[8]  = 32'd0;         d_e[8]  = 32'hFFFF_FFFF;
        d_op[9]  = 3'd7; d_a[9]  = 32'h1234;       d_b[9]  = 32'd0;         d_e[9]  = 32'h1234;
        d_op[10] = 3'd4; d_a[10] = 32'h8000_0000; d_b[10] = 32'hFFFF_FFFF; d_e[10] = 32'h8000_0000;
        d_op[11] = 3'd6; d_a[11] = 32'h8000_0000; d_b[11] = 32'hFFFF_FFFF; d_e[11] = 32'h0;

        rst = 1'b1;
        flush = 1'b0;
        for (int s = 0; s < 2; s++) begin
            iv[s] = 1'b0; opx[s] = '0; ax[s] = '0; bx[s] = '0; ordy[s] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check($sformatf("dut%0d reset out_valid", s), ov[s], 0);
            check($sformatf("dut%0d reset busy", s), bsy[s], 0);
            check($sformatf("dut%0d reset result", s), res[s], 0);
            check($sformatf("dut%0d reset in_ready", s), irdy[s], 1);
        end
        rst = 1'b0;

        // Directed cases; first one also exercises 10 cycles of backpressure.
        for (int s = 0; s < 2; s++)
            for (int t = 0; t < 12; t++)
                run_op(s, d_op[t], d_a[t], d_b[t], d_e[t], (t == 0) ? 10 : 0);

        // Random operations against the reference model.
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 30; i++) begin
                ro = 3'($urandom_range(0, 7));
                case ($urandom_range(0, 3))
                    0:       ra = 32'($urandom_range(0, 300));
                    1:       ra = 32'h8000_0000;
                    2:       ra = 32'hFFFF_FFFF;
                    default: ra = $urandom();
                endcase
                case ($urandom_range(0, 5))
                    0:       rb = 32'h0;
                    1:       rb = 32'hFFFF_FFFF;
                    2:       rb = 32'($urandom_range(1, 20));
                    default: rb = $urandom();
                endcase
                run_op(s, ro, ra, rb, ref_model(ro, ra, rb), $urandom_range(0, 3));
            end
        end

        // Flush during iterations.
        flush_mid(0, 4);
        flush_mid(1, 2);

        // Flush together with a valid request suppresses acceptance.
        @(negedge clk);
        iv[0] = 1'b1; opx[0] = 3'd0; ax[0] = 32'd3; bx[0] = 32'd5;
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv[0] = 1'b0;
        flush = 1'b0;
        check("dut0 flush_accept busy", bsy[0], 0);
        check("dut0 flush_accept in_ready", irdy[0], 1);
        watch_no_valid(0, 40, "flush_accept_no_valid");

        // Asynchronous reset in the middle of a computation.
        @(negedge clk);
        iv[0] = 1'b1; opx[0] = 3'd4; ax[0] = 32'd1000; bx[0] = 32'd3;
        @(posedge clk);
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("dut0 async_rst out_valid", ov[0], 0);
        check("dut0 async_rst busy", bsy[0], 0);
        check("dut0 async_rst result", res[0], 0);
        check("dut0 async_rst in_ready", irdy[0], 1);
        @(negedge clk);
        rst = 1'b0;
        run_op(0, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
        run_op(1, 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);

        // ---------------- final report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
